// File: rtl/tree_adder_pkg.sv
// rtl/tree_adder_pkg.sv - shared constants, state enum and sizing helper for the tree-adder family
package tree_adder_pkg;

    localparam int DEFAULT_DIGIT_W    = 4;
    localparam int DEFAULT_NUM_DIGITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of a digit index counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_expand.sv
// rtl/carry_expand.sv - expands a group carry-in into per-bit carries from generate/propagate
module carry_expand #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] g_i,
    input  logic [DIGIT_W-1:0] p_i,
    input  logic               c0_i,
    output logic [DIGIT_W:0]   c_o
);

    logic ripple;

    // Ripple the group carry through each bit; c_o[k] is the carry into bit k.
    always_comb begin
        ripple = c0_i;
        c_o    = '0;
        c_o[0] = c0_i;
        for (int i = 0; i < DIGIT_W; i++) begin
            ripple   = g_i[i] | (p_i[i] & ripple);
            c_o[i+1] = ripple;
        end
    end

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - LSB-first digit-serial adder with registered carry and sum digit
module digit_serial_adder
    import tree_adder_pkg::*;
#(
    parameter int DIGIT_W    = DEFAULT_DIGIT_W,
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic [DIGIT_W-1:0] a_digit,
    input  logic [DIGIT_W-1:0] b_digit,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] sum_digit,
    output logic               out_first,
    output logic               out_last,
    output logic               cout,
    output logic               ovf
);

    localparam int             CW       = cnt_width(NUM_DIGITS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NUM_DIGITS - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 carry_q, carry_d;
    logic                 out_valid_q, out_valid_d;
    logic [DIGIT_W-1:0]   sum_q, sum_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 cout_q, cout_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 take;
    logic [CW-1:0]        idx;
    logic                 is_last;
    logic                 c0;
    logic [DIGIT_W-1:0]   g, p;
    logic [DIGIT_W:0]     c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A non-first digit seen while idle belongs to no operand and is dropped.
    assign take     = accept && (in_first || state_q == RUN);
    assign idx      = in_first ? '0 : cnt_q;
    assign is_last  = (idx == LAST_IDX);
    assign c0       = in_first ? cin : carry_q;
    assign g        = a_digit & b_digit;
    assign p        = a_digit ^ b_digit;

    carry_expand #(.DIGIT_W(DIGIT_W)) u_carry_expand (
        .g_i  (g),
        .p_i  (p),
        .c0_i (c0),
        .c_o  (c)
    );

    // Next-state for FSM, digit counter, carry and the registered output digit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        first_d     = first_q;
        last_d      = last_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (take) begin
            state_d     = is_last ? IDLE : RUN;
            cnt_d       = is_last ? '0 : idx + CW'(1);
            carry_d     = c[DIGIT_W];
            out_valid_d = 1'b1;
            sum_d       = p ^ c[DIGIT_W-1:0];
            first_d     = in_first;
            last_d      = is_last;
            cout_d      = is_last ? c[DIGIT_W] : 1'b0;
            ovf_d       = is_last ? (c[DIGIT_W] ^ c[DIGIT_W-1]) : 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any partial operand and pending digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            first_q     <= first_d;
            last_q      <= last_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum_digit = sum_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - directed self-checking bench for digit_serial_adder
module tb_digit_serial_adder;

    localparam int DW = 4;
    localparam int ND = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_first;
    logic [DW-1:0] a_digit;
    logic [DW-1:0] b_digit;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] sum_digit;
    logic          out_first;
    logic          out_last;
    logic          cout;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.DIGIT_W(DW), .NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .a_digit   (a_digit),
        .b_digit   (b_digit),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_digit (sum_digit),
        .out_first (out_first),
        .out_last  (out_last),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Streams one full operand and checks every result digit, flags and throughput.
    task automatic run_operand(input logic [31:0] a, input logic [31:0] b, input logic ci,
                               input logic [31:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                               input int stall_at, input int stall_len, input int exp_cycles,
                               input string name);
        int di, oi, cyc, stall_left;
        logic [DW+3:0] got, exp;
        di = 0; oi = 0; cyc = 0; stall_left = stall_len;
        while (oi < ND && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (out_valid && oi == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (di < ND) begin
                in_valid = 1'b1;
                in_first = (di == 0);
                a_digit  = a[4*di +: 4];
                b_digit  = b[4*di +: 4];
                cin      = (di == 0) ? ci : ~ci;
            end else begin
                in_valid = 1'b0;
                in_first = 1'b0;
            end
            #1;
            if (out_valid) begin
                got = {sum_digit, out_first, out_last, cout, ovf};
                exp = {exp_sum[4*oi +: 4], oi == 0, oi == ND-1,
                       (oi == ND-1) ? exp_cout : 1'b0, (oi == ND-1) ? exp_ovf : 1'b0};
                n_cmp++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL %s digit%0d {sum,first,last,cout,ovf}: got %b required %b", name, oi, got, exp);
                end
                if (!out_ready) begin
                    n_cmp++;
                    if (in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL %s stall in_ready: got %b required 0", name, in_ready);
                    end
                end else begin
                    oi++;
                end
            end
            if (in_valid && in_ready) di++;
        end
        n_cmp++;
        if (oi != ND) begin
            n_err++;
            $display("FAIL %s digit count: got %0d required %0d", name, oi, ND);
        end
        n_cmp++;
        if (cyc != exp_cycles) begin
            n_err++;
            $display("FAIL %s cycles: got %0d required %0d", name, cyc, exp_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; a_digit = '0; b_digit = '0;
        cin = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, sum_digit, out_first, out_last, cout, ovf, in_ready} !== 10'b0000000001) begin
            n_err++;
            $display("FAIL reset outputs: got %b required 0000000001",
                     {out_valid, sum_digit, out_first, out_last, cout, ovf, in_ready});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_operand(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, -1, 0, 9, "ff_plus_1");
    endtask

    task automatic test_carry_chain();
        run_operand(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, -1, 0, 9, "all_ones_plus_b");
        run_operand(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, -1, 0, 9, "all_ones_plus_cin");
    endtask

    task automatic test_overflow();
        run_operand(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, -1, 0, 9, "signed_ovf");
    endtask

    task automatic test_backpressure();
        run_operand(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 2, 5, 14, "stall");
    endtask

    task automatic test_discard();
        @(negedge clk);
        in_valid = 1'b1; in_first = 1'b0; a_digit = 4'h5; b_digit = 4'h5; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_discard out_valid: got %b required 0", out_valid);
        end
        run_operand(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, -1, 0, 9, "after_discard");
    endtask

    task automatic test_restart();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_first = (k == 0); a_digit = 4'hF; b_digit = 4'hF;
            cin = 1'b1; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, sum_digit} !== 5'b1_1111) begin
            n_err++;
            $display("FAIL partial digit2: got %b required 11111", {out_valid, sum_digit});
        end
        run_operand(32'h00000009, 32'h00000007, 1'b0, 32'h00000010, 1'b0, 1'b0, -1, 0, 9, "restart");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_first = (k == 0); a_digit = 4'h9; b_digit = 4'h9;
            cin = 1'b0; out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset out_valid: got %b required 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, sum_digit, out_first, out_last} !== 7'b0) begin
            n_err++;
            $display("FAIL async_reset outputs: got %b required 0000000",
                     {out_valid, sum_digit, out_first, out_last});
        end
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        run_operand(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, -1, 0, 9, "post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_overflow();
        test_backpressure();
        test_discard();
        test_restart();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
